// File: rtl/ccis_c0_rd_arbiter.sv
// Channel-0 read arbiter: per-client request FIFOs, round-robin issue onto c0 Tx,
// and tag-based steering of c0 Rx responses back to the issuing client.
module ccis_c0_rd_arbiter #(
  parameter  int N_PORTS         = 2,
  parameter  int ADDR_W          = 32,
  parameter  int MDATA_W         = 13,
  parameter  int FIFO_DEPTH      = 16,
  parameter  int SLACK           = 8,
  parameter  int MAX_OUTSTANDING = 64,
  localparam int PORT_W          = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int CL_MDATA_W      = MDATA_W - PORT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_PORTS-1:0]             cl_rdValid,
  input  logic [N_PORTS*ADDR_W-1:0]      cl_addr,
  input  logic [N_PORTS*CL_MDATA_W-1:0]  cl_mdata,
  output logic [N_PORTS-1:0]             cl_almostFull,
  input  logic                           c0_almostFull,
  output logic                           tx_rdValid,
  output logic [ADDR_W-1:0]              tx_addr,
  output logic [MDATA_W-1:0]             tx_mdata,
  input  logic                           rx_rdValid,
  input  logic [MDATA_W-1:0]             rx_mdata,
  input  logic [511:0]                   rx_data,
  output logic [N_PORTS-1:0]             cl_rx_rdValid,
  output logic [CL_MDATA_W-1:0]          cl_rx_mdata,
  output logic [511:0]                   cl_rx_data,
  output logic                           err_bad_tag
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int ENT_W     = ADDR_W + CL_MDATA_W;
  localparam bit FULL_TAGS = (N_PORTS == (1 << PORT_W));

  logic [ENT_W-1:0]      mem_q    [N_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q [N_PORTS];
  logic [PTR_W-1:0]      rd_ptr_d [N_PORTS];
  logic [PTR_W-1:0]      wr_ptr_q [N_PORTS];
  logic [PTR_W-1:0]      wr_ptr_d [N_PORTS];
  logic [CNT_W-1:0]      occ_q    [N_PORTS];
  logic [CNT_W-1:0]      occ_d    [N_PORTS];
  logic [OUT_W-1:0]      out_q    [N_PORTS];
  logic [OUT_W-1:0]      out_d    [N_PORTS];
  logic [PORT_W-1:0]     rr_q, rr_d;
  logic [N_PORTS-1:0]    af_q, af_d;
  logic [N_PORTS-1:0]    eligible, wr_en, deq_v, dec_v, full_v;
  logic [2*N_PORTS-1:0]  elig_rot;
  logic                  gnt_vld;
  logic [PORT_W-1:0]     gnt_idx;
  logic [ENT_W-1:0]      head;
  logic [PORT_W-1:0]     rx_tag;
  logic                  tag_ok, rx_hit;
  logic                  tx_vld_q, tx_vld_d;
  logic [ADDR_W-1:0]     tx_addr_q, tx_addr_d;
  logic [MDATA_W-1:0]    tx_mdata_q, tx_mdata_d;
  logic [N_PORTS-1:0]    rxv_q, rxv_d;
  logic [CL_MDATA_W-1:0] rxmd_q, rxmd_d;
  logic [511:0]          rxdata_q, rxdata_d;
  logic                  err_q, err_d;

  assign rx_tag = rx_mdata[MDATA_W-1 -: PORT_W];

  // With a power-of-two port count every tag value names a real port.
  if (FULL_TAGS) begin : g_full_tags
    assign tag_ok = 1'b1;
  end else begin : g_part_tags
    assign tag_ok = (rx_tag < PORT_W'(N_PORTS));
  end

  assign rx_hit = rx_rdValid && tag_ok;

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      eligible[p] = (occ_q[p] != '0) && (int'(out_q[p]) < MAX_OUTSTANDING);
    end
    elig_rot = {eligible, eligible} >> rr_q;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!gnt_vld && elig_rot[i] && !c0_almostFull) begin
        gnt_vld = 1'b1;
        gnt_idx = (int'(rr_q) + i >= N_PORTS) ? PORT_W'(int'(rr_q) + i - N_PORTS)
                                               : PORT_W'(int'(rr_q) + i);
      end
    end
  end

  always_comb begin
    err_d = err_q;
    head  = '0;
    rr_d  = rr_q;
    for (int p = 0; p < N_PORTS; p++) begin
      deq_v[p]    = gnt_vld && (gnt_idx == PORT_W'(p));
      full_v[p]   = (int'(occ_q[p]) == FIFO_DEPTH);
      // A dequeue in the same cycle frees the slot, so a full FIFO can still accept.
      wr_en[p]    = cl_rdValid[p] && (!full_v[p] || deq_v[p]);
      if (cl_rdValid[p] && full_v[p] && !deq_v[p]) err_d = 1'b1;
      wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(wr_en[p]);
      rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(deq_v[p]);
      occ_d[p]    = occ_q[p] + CNT_W'(wr_en[p]) - CNT_W'(deq_v[p]);
      af_d[p]     = (int'(occ_d[p]) + SLACK >= FIFO_DEPTH);
      if (deq_v[p]) head = mem_q[p][rd_ptr_q[p]];
      dec_v[p]    = rx_hit && (rx_tag == PORT_W'(p));
      rxv_d[p]    = dec_v[p];
      out_d[p]    = out_q[p];
      if (deq_v[p] && !dec_v[p]) begin
        out_d[p] = out_q[p] + OUT_W'(1);
      end else if (dec_v[p] && !deq_v[p]) begin
        if (out_q[p] == '0) err_d = 1'b1;
        else                out_d[p] = out_q[p] - OUT_W'(1);
      end
    end
    if (rx_rdValid && !tag_ok) err_d = 1'b1;
    if (gnt_vld) rr_d = (int'(gnt_idx) == N_PORTS - 1) ? '0 : gnt_idx + PORT_W'(1);
    tx_vld_d   = gnt_vld;
    tx_addr_d  = head[ENT_W-1 -: ADDR_W];
    tx_mdata_d = {gnt_idx, head[CL_MDATA_W-1:0]};
    rxmd_d     = rx_mdata[CL_MDATA_W-1:0];
    rxdata_d   = rx_data;
  end

  // Storage is not reset; emptiness is tracked by the pointers and occupancy.
  always_ff @(posedge clk) begin
    for (int p = 0; p < N_PORTS; p++) begin
      if (wr_en[p]) mem_q[p][wr_ptr_q[p]] <= {cl_addr[p*ADDR_W +: ADDR_W],
                                              cl_mdata[p*CL_MDATA_W +: CL_MDATA_W]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < N_PORTS; p++) begin
        rd_ptr_q[p] <= '0;
        wr_ptr_q[p] <= '0;
        occ_q[p]    <= '0;
        out_q[p]    <= '0;
      end
      rr_q       <= '0;
      af_q       <= '1;
      tx_vld_q   <= 1'b0;
      tx_addr_q  <= '0;
      tx_mdata_q <= '0;
      rxv_q      <= '0;
      rxmd_q     <= '0;
      rxdata_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        rd_ptr_q[p] <= rd_ptr_d[p];
        wr_ptr_q[p] <= wr_ptr_d[p];
        occ_q[p]    <= occ_d[p];
        out_q[p]    <= out_d[p];
      end
      rr_q       <= rr_d;
      af_q       <= af_d;
      tx_vld_q   <= tx_vld_d;
      tx_addr_q  <= tx_addr_d;
      tx_mdata_q <= tx_mdata_d;
      rxv_q      <= rxv_d;
      rxmd_q     <= rxmd_d;
      rxdata_q   <= rxdata_d;
      err_q      <= err_d;
    end
  end

  assign cl_almostFull = af_q;
  assign tx_rdValid    = tx_vld_q;
  assign tx_addr       = tx_addr_q;
  assign tx_mdata      = tx_mdata_q;
  assign cl_rx_rdValid = rxv_q;
  assign cl_rx_mdata   = rxmd_q;
  assign cl_rx_data    = rxdata_q;
  assign err_bad_tag   = err_q;

endmodule

// File: doc/ccis_c0_rd_arbiter.md
Name: ccis_c0_rd_arbiter

Overview:
- Shares the single CCI-S channel-0 read-request path (c0 Tx) among N_PORTS independent clients.
- Each client has its own request FIFO; a round-robin arbiter issues at most one read per cycle; the winning port index is carried in the upper mdata bits.
- Read responses (c0 Rx) are steered back to the owning client by that tag, with the tag bits stripped.
- Sits between the client engines and the platform c0 Tx/Rx ports.

Parameters:
- N_PORTS, 2, number of clients (2..8); PORT_W = max(1, clog2(N_PORTS)).
- ADDR_W, 32, cache-line address width.
- MDATA_W, 13, platform mdata width; client mdata width CL_MDATA_W = MDATA_W - PORT_W.
- FIFO_DEPTH, 16, per-port request FIFO entries (power of 2, at least 2*SLACK).
- SLACK, 8, requests a client may still issue after cl_almostFull asserts.
- MAX_OUTSTANDING, 64, per-port in-flight read limit.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cl_rdValid  in  N_PORTS  per-client read request strobe
- cl_addr  in  N_PORTS*ADDR_W  per-client address, port p at bits [p*ADDR_W +: ADDR_W]
- cl_mdata  in  N_PORTS*CL_MDATA_W  per-client mdata
- cl_almostFull  out  N_PORTS  per-client backpressure
- c0_almostFull  in  1  platform c0 Tx almost-full
- tx_rdValid  out  1  issued read
- tx_addr  out  ADDR_W  issued address
- tx_mdata  out  MDATA_W  {port index, client mdata}
- rx_rdValid  in  1  platform read response valid
- rx_mdata  in  MDATA_W  response mdata
- rx_data  in  512  response line
- cl_rx_rdValid  out  N_PORTS  one-hot response strobe
- cl_rx_mdata  out  CL_MDATA_W  response mdata with tag stripped (shared by all ports)
- cl_rx_data  out  512  response data (shared by all ports)
- err_bad_tag  out  1  sticky error flag

Behaviour:
- Reset: all FIFOs empty, outstanding counters 0, round-robin pointer = port 0, err_bad_tag = 0. All valid outputs are 0 during and after reset until traffic arrives; data outputs are don't-care.
- Enqueue: cl_rdValid[p] writes {addr, mdata} into FIFO p in the same cycle.
- cl_almostFull[p] is registered. It is 1 when FIFO p occupancy + SLACK >= FIFO_DEPTH, and is also 1 during reset.
- An enqueue into a full FIFO is a client protocol violation: the request is dropped and err_bad_tag is set.
- Eligibility: port p is eligible when FIFO p is non-empty and outstanding[p] < MAX_OUTSTANDING.
- Grant: when c0_almostFull == 0, the arbiter picks the first eligible port at or after the pointer, wrapping at N_PORTS. The pointer then moves to winner+1 mod N_PORTS. No grant is made while c0_almostFull == 1.
- Issue latency: the grant dequeues the FIFO head; tx_rdValid/tx_addr/tx_mdata are registered and appear 1 cycle after the grant.
- tx_mdata = {winner[PORT_W-1:0], client mdata}. tx_rdValid = 0 in cycles with no grant.
- Throughput: 1 read per cycle when c0_almostFull is low. Back-to-back grants to the same port are allowed only if no other port is eligible.
- Response: on rx_rdValid, tag t = rx_mdata[MDATA_W-1 -: PORT_W].
  - If t < N_PORTS: cl_rx_rdValid[t] = 1, cl_rx_mdata = rx_mdata[CL_MDATA_W-1:0], cl_rx_data = rx_data, registered with 1-cycle latency, and outstanding[t] decrements.
  - If t >= N_PORTS: the response is dropped and err_bad_tag is set (sticky until reset).
- Counters: grant and response on the same port in the same cycle leave outstanding unchanged. A decrement at 0 is ignored and sets err_bad_tag.
- Enqueue and dequeue on the same FIFO in the same cycle leave occupancy unchanged, including when the FIFO is full (the dequeue frees the slot).
- Reset asserted mid-operation: queued and in-flight state is discarded immediately. Responses that arrive later carry stale tags; those are delivered if the tag is valid, but counter decrements at 0 are ignored and flagged.

Test Plan:
- Single port: N_PORTS=2, port 0 issues 4 reads (addr 0x100..0x103, mdata 1..4) -> tx_rdValid high for 4 consecutive cycles starting 2 cycles after the first request; tx_mdata = {1'b0, mdata} each cycle.
- Fairness: both ports keep their FIFOs non-empty for 20 grants -> issued tags alternate 0,1,0,1…, 10 grants each.
- Backpressure: fill port 1 with 8 requests while c0_almostFull=1 -> tx_rdValid stays 0 and cl_almostFull[1]=1 (8+8>=16). Release c0_almostFull -> 8 issues, then cl_almostFull[1]=0.
- Outstanding limit: MAX_OUTSTANDING=4, 6 requests and no responses -> exactly 4 issued. One response with tag 0 -> the 5th issues within 2 cycles.
- Response routing: rx_mdata = {1'b1, 12'h0AB} -> cl_rx_rdValid = 2'b10 and cl_rx_mdata = 12'h0AB one cycle later. With N_PORTS=3, a tag of 3 -> no strobe and err_bad_tag = 1.
- Reset mid-burst: assert reset with 5 requests queued -> tx_rdValid = 0 and all counters 0 immediately. After release, a new request issues normally.
